control_sequencer: RTL and testbench

- Moore-style control unit that sequences the single-bus datapath through fetch and execute steps.
- Decodes the 5-bit opcode from IR[31:27] into one-cycle control states.
- Drives every register-enable, bus-driver and memory strobe the datapath exposes.
- Replaces the hand-timed testbench stimulus; the datapath plus this block executes programs autonomously.

---
 rtl/control_sequencer_if.sv | 37 +++
 rtl/control_sequencer.sv | 177 +++++++++++++++++
 tb/tb_control_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the single-bus datapath.
// master: sequencer side (takes opcode/CON_FF/Stop, drives every strobe).
// slave : datapath side (drives opcode/CON_FF/Stop, receives every strobe).
interface control_sequencer_if #(
  parameter int unsigned STATE_W = 5
);
  // Datapath status into the sequencer.
  logic [4:0]         opcode;
  logic               CON_FF;
  logic               Stop;
  // Bus drivers.
  logic               PCout, ZLowout, ZHighout, MDRout, HIout, LOout;
  logic               Cout, BAout, InPortOut, Rout;
  // Register loads.
  logic               PCin, IncPC, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn;
  logic               HIin, LOin, CONin, Rin, OutPortIn;
  // Register-field selects and memory strobes.
  logic               GRA, GRB, GRC;
  logic               Read, RAMin;
  // Status.
  logic               Run;
  logic [STATE_W-1:0] Present_state;

  modport master (
    input  opcode, CON_FF, Stop,
    output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, InPortOut, Rout,
    output PCin, IncPC, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, Rin,
    output OutPortIn, GRA, GRB, GRC, Read, RAMin, Run, Present_state
  );

  modport slave (
    output opcode, CON_FF, Stop,
    input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, InPortOut, Rout,
    input  PCin, IncPC, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, Rin,
    input  OutPortIn, GRA, GRB, GRC, Read, RAMin, Run, Present_state
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control unit sequencing the single-bus datapath through fetch (T0-T2)
// and per-class execute steps, one state per clock.
// Ports: Clock, Clear (sync active-high reset), ctrl (control_sequencer_if.master:
// opcode/CON_FF/Stop in; bus drivers, register loads, selects, memory strobes,
// Run and Present_state out).
// Strobes are registered from the next state, so they line up exactly with the
// state they belong to; only branch PCin in T6 is gated live by CON_FF.
module control_sequencer #(
  parameter int unsigned STATE_W       = 5,
  parameter bit          HALT_ON_UNDEF = 1'b0
) (
  input  logic                 Clock,
  input  logic                 Clear,
  control_sequencer_if.master  ctrl
);

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110, OP_MUL  = 5'b01111, OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_BRX  = 5'b10010, OP_JR   = 5'b10011, OP_IN   = 5'b10101;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  // Execute states are shared where classes assert identical strobes; the
  // held IR opcode steers the split afterwards.
  typedef enum logic [STATE_W-1:0] {
    S_RESET, S_T0, S_T1, S_T2, S_HALT,
    S_RB_Y,   // GRB Rout Yin         (ALU reg / ALU imm T3)
    S_RC_Z,   // GRC Rout ZLowIn      (ALU reg T4)
    S_BA_Y,   // GRB BAout Yin        (ldi / ld / st T3)
    S_C_Z,    // Cout ZLowIn          (imm / ldi / ld / st T4)
    S_WB,     // ZLowout GRA Rin      (ALU / imm / ldi T5)
    S_Z_MAR,  // ZLowout MARin        (ld / st T5)
    S_LD6, S_LD7, S_ST6, S_ST7,
    S_MD3, S_MD4, S_MD5, S_MD6,
    S_BR3, S_BR4, S_BR5, S_BR6,
    S_JR3, S_IN3, S_OUT3, S_MFHI3, S_MFLO3
  } state_t;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, hiout, loout, cout, baout, inportout, rout;
    logic pcin, incpc, marin, mdrin, irin, yin, zlowin, zhighin, hiin, loin, conin, rin;
    logic outportin, gra, grb, grc, read, ramin, run;
    logic br_gate;  // branch T6: PCin follows CON_FF
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  // Strobe decode for a given state.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c     = '0;
    c.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      S_T0:    begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zlowin = 1'b1; end
      S_T1:    begin c.zlowout = 1'b1; c.pcin = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; end
      S_T2:    begin c.mdrout = 1'b1; c.irin = 1'b1; end
      S_RB_Y:  begin c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
      S_RC_Z:  begin c.grc = 1'b1; c.rout = 1'b1; c.zlowin = 1'b1; end
      S_BA_Y:  begin c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1; end
      S_C_Z:   begin c.cout = 1'b1; c.zlowin = 1'b1; end
      S_WB:    begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
      S_Z_MAR: begin c.zlowout = 1'b1; c.marin = 1'b1; end
      S_LD6:   begin c.read = 1'b1; c.mdrin = 1'b1; end
      S_LD7:   begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
      S_ST6:   begin c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1; end
      S_ST7:   begin c.ramin = 1'b1; end
      S_MD3:   begin c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
      S_MD4:   begin c.grb = 1'b1; c.rout = 1'b1; c.zlowin = 1'b1; c.zhighin = 1'b1; end
      S_MD5:   begin c.zlowout = 1'b1; c.loin = 1'b1; end
      S_MD6:   begin c.zhighout = 1'b1; c.hiin = 1'b1; end
      S_BR3:   begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
      S_BR4:   begin c.pcout = 1'b1; c.yin = 1'b1; end
      S_BR5:   begin c.cout = 1'b1; c.zlowin = 1'b1; end
      S_BR6:   begin c.zlowout = 1'b1; c.br_gate = 1'b1; end
      S_JR3:   begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
      S_IN3:   begin c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
      S_OUT3:  begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; end
      S_MFHI3: begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
      S_MFLO3: begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Next-state: fetch, class dispatch at T2, boundary checks Stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        case (ctrl.opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI:    state_d = S_RB_Y;
          OP_LDI, OP_LD, OP_ST:        state_d = S_BA_Y;
          OP_MUL, OP_DIV:              state_d = S_MD3;
          OP_BRX:                      state_d = S_BR3;
          OP_JR:                       state_d = S_JR3;
          OP_IN:                       state_d = S_IN3;
          OP_OUT:                      state_d = S_OUT3;
          OP_MFHI:                     state_d = S_MFHI3;
          OP_MFLO:                     state_d = S_MFLO3;
          OP_NOP:                      state_d = S_T0;
          OP_HALT:                     state_d = S_HALT;
          default:                     state_d = HALT_ON_UNDEF ? S_HALT : S_T0;
        endcase
      end
      S_RB_Y:  state_d = (ctrl.opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) ? S_RC_Z : S_C_Z;
      S_RC_Z:  state_d = S_WB;
      S_BA_Y:  state_d = S_C_Z;
      S_C_Z:   state_d = (ctrl.opcode inside {OP_LD, OP_ST}) ? S_Z_MAR : S_WB;
      S_Z_MAR: state_d = (ctrl.opcode == OP_LD) ? S_LD6 : S_ST6;
      S_LD6:   state_d = S_LD7;
      S_ST6:   state_d = S_ST7;
      S_MD3:   state_d = S_MD4;
      S_MD4:   state_d = S_MD5;
      S_MD5:   state_d = S_MD6;
      S_BR3:   state_d = S_BR4;
      S_BR4:   state_d = S_BR5;
      S_BR5:   state_d = S_BR6;
      S_WB, S_LD7, S_ST7, S_MD6, S_BR6,
      S_JR3, S_IN3, S_OUT3, S_MFHI3, S_MFLO3:
               state_d = ctrl.Stop ? S_HALT : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State and strobe registers; Clear overrides everything, including Stop.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign ctrl.PCout         = ctrl_q.pcout;
  assign ctrl.ZLowout       = ctrl_q.zlowout;
  assign ctrl.ZHighout      = ctrl_q.zhighout;
  assign ctrl.MDRout        = ctrl_q.mdrout;
  assign ctrl.HIout         = ctrl_q.hiout;
  assign ctrl.LOout         = ctrl_q.loout;
  assign ctrl.Cout          = ctrl_q.cout;
  assign ctrl.BAout         = ctrl_q.baout;
  assign ctrl.InPortOut     = ctrl_q.inportout;
  assign ctrl.Rout          = ctrl_q.rout;
  assign ctrl.PCin          = ctrl_q.pcin | (ctrl_q.br_gate & ctrl.CON_FF);
  assign ctrl.IncPC         = ctrl_q.incpc;
  assign ctrl.MARin         = ctrl_q.marin;
  assign ctrl.MDRin         = ctrl_q.mdrin;
  assign ctrl.IRin          = ctrl_q.irin;
  assign ctrl.Yin           = ctrl_q.yin;
  assign ctrl.ZLowIn        = ctrl_q.zlowin;
  assign ctrl.ZHighIn       = ctrl_q.zhighin;
  assign ctrl.HIin          = ctrl_q.hiin;
  assign ctrl.LOin          = ctrl_q.loin;
  assign ctrl.CONin         = ctrl_q.conin;
  assign ctrl.Rin           = ctrl_q.rin;
  assign ctrl.OutPortIn     = ctrl_q.outportin;
  assign ctrl.GRA           = ctrl_q.gra;
  assign ctrl.GRB           = ctrl_q.grb;
  assign ctrl.GRC           = ctrl_q.grc;
  assign ctrl.Read          = ctrl_q.read;
  assign ctrl.RAMin         = ctrl_q.ramin;
  assign ctrl.Run           = ctrl_q.run;
  assign ctrl.Present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle strobe vectors compared against a
// table of expected steps built from the instruction set description.
module tb_control_sequencer;

  localparam int PCOUT = 0, ZLOWOUT = 1, ZHIGHOUT = 2, MDROUT = 3, HIOUT = 4, LOOUT = 5;
  localparam int COUT = 6, BAOUT = 7, INPORTOUT = 8, ROUT = 9;
  localparam int PCIN = 10, INCPC = 11, MARIN = 12, MDRIN = 13, IRIN = 14, YIN = 15;
  localparam int ZLOWIN = 16, ZHIGHIN = 17, HIIN = 18, LOIN = 19, CONIN = 20, RIN = 21;
  localparam int OUTPORTIN = 22, GRA = 23, GRB = 24, GRC = 25, READ = 26, RAMIN = 27, RUN = 28;

  typedef logic [28:0] vec_t;

  logic Clock, Clear;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t exp_q[$];
  vec_t obs_q[$];
  vec_t got;

  control_sequencer_if #(.STATE_W(5)) ctrl ();

  control_sequencer #(.STATE_W(5), .HALT_ON_UNDEF(1'b0)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .ctrl  (ctrl)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t m(input int i);
    return vec_t'(1) << i;
  endfunction

  function automatic vec_t t0v();
    return m(PCOUT) | m(MARIN) | m(INCPC) | m(ZLOWIN) | m(RUN);
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v = '0;
    v[PCOUT] = ctrl.PCout;   v[ZLOWOUT] = ctrl.ZLowout; v[ZHIGHOUT] = ctrl.ZHighout;
    v[MDROUT] = ctrl.MDRout; v[HIOUT] = ctrl.HIout;     v[LOOUT] = ctrl.LOout;
    v[COUT] = ctrl.Cout;     v[BAOUT] = ctrl.BAout;     v[INPORTOUT] = ctrl.InPortOut;
    v[ROUT] = ctrl.Rout;     v[PCIN] = ctrl.PCin;       v[INCPC] = ctrl.IncPC;
    v[MARIN] = ctrl.MARin;   v[MDRIN] = ctrl.MDRin;     v[IRIN] = ctrl.IRin;
    v[YIN] = ctrl.Yin;       v[ZLOWIN] = ctrl.ZLowIn;   v[ZHIGHIN] = ctrl.ZHighIn;
    v[HIIN] = ctrl.HIin;     v[LOIN] = ctrl.LOin;       v[CONIN] = ctrl.CONin;
    v[RIN] = ctrl.Rin;       v[OUTPORTIN] = ctrl.OutPortIn;
    v[GRA] = ctrl.GRA;       v[GRB] = ctrl.GRB;         v[GRC] = ctrl.GRC;
    v[READ] = ctrl.Read;     v[RAMIN] = ctrl.RAMin;     v[RUN] = ctrl.Run;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_q.push_back(v | m(RUN));
  endtask

  // Reference: every step the instruction spends, fetch included.
  task automatic build_expect(input logic [4:0] op, input logic con);
    exp_q.delete();
    step(m(PCOUT) | m(MARIN) | m(INCPC) | m(ZLOWIN));
    step(m(ZLOWOUT) | m(PCIN) | m(READ) | m(MDRIN));
    step(m(MDROUT) | m(IRIN));
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        step(m(GRB) | m(ROUT) | m(YIN));
        step(m(GRC) | m(ROUT) | m(ZLOWIN));
        step(m(ZLOWOUT) | m(GRA) | m(RIN));
      end
      5'b01100, 5'b01101, 5'b01110: begin
        step(m(GRB) | m(ROUT) | m(YIN));
        step(m(COUT) | m(ZLOWIN));
        step(m(ZLOWOUT) | m(GRA) | m(RIN));
      end
      5'b00001: begin
        step(m(GRB) | m(BAOUT) | m(YIN));
        step(m(COUT) | m(ZLOWIN));
        step(m(ZLOWOUT) | m(GRA) | m(RIN));
      end
      5'b00000: begin
        step(m(GRB) | m(BAOUT) | m(YIN));
        step(m(COUT) | m(ZLOWIN));
        step(m(ZLOWOUT) | m(MARIN));
        step(m(READ) | m(MDRIN));
        step(m(MDROUT) | m(GRA) | m(RIN));
      end
      5'b00010: begin
        step(m(GRB) | m(BAOUT) | m(YIN));
        step(m(COUT) | m(ZLOWIN));
        step(m(ZLOWOUT) | m(MARIN));
        step(m(GRA) | m(ROUT) | m(MDRIN));
        step(m(RAMIN));
      end
      5'b01111, 5'b10000: begin
        step(m(GRA) | m(ROUT) | m(YIN));
        step(m(GRB) | m(ROUT) | m(ZLOWIN) | m(ZHIGHIN));
        step(m(ZLOWOUT) | m(LOIN));
        step(m(ZHIGHOUT) | m(HIIN));
      end
      5'b10010: begin
        step(m(GRA) | m(ROUT) | m(CONIN));
        step(m(PCOUT) | m(YIN));
        step(m(COUT) | m(ZLOWIN));
        step(m(ZLOWOUT) | (con ? m(PCIN) : vec_t'(0)));
      end
      5'b10011: step(m(GRA) | m(ROUT) | m(PCIN));
      5'b10101: step(m(INPORTOUT) | m(GRA) | m(RIN));
      5'b10110: step(m(GRA) | m(ROUT) | m(OUTPORTIN));
      5'b10111: step(m(HIOUT) | m(GRA) | m(RIN));
      5'b11000: step(m(LOOUT) | m(GRA) | m(RIN));
      default: ;  // nop, halt and undefined opcodes: fetch only
    endcase
  endtask

  // Runs one instruction from T0, capturing outputs each cycle; ends #1 after
  // the edge that leaves the instruction.
  task automatic exec(input logic [4:0] op, input logic con, input logic stop_mid,
                      input logic stop_end);
    ctrl.opcode = op;
    ctrl.CON_FF = con;
    build_expect(op, con);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      ctrl.Stop = (i == exp_q.size() - 1) ? stop_end : stop_mid;
      obs_q.push_back(sample());
      @(posedge Clock); #1;
    end
    ctrl.Stop = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic recover();
    Clear = 1'b1; tick();
    Clear = 1'b0; tick();
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = sample(); vectors++;
      if (got !== '0) begin
        miscompares++; $display("FAIL reset_hold%0d got %h exp %h", i, got, vec_t'(0));
      end
    end
    Clear = 1'b0; tick();
    got = sample(); vectors++;
    if (got !== t0v()) begin
      miscompares++; $display("FAIL reset_to_t0 got %h exp %h", got, t0v());
    end
  endtask

  task automatic test_alu_reg();
    logic [4:0] ops[4];
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110};
    foreach (ops[k]) begin
      exec(ops[k], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL alu op%b cyc%0d got %h exp %h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
      got = sample(); vectors++;
      if (got !== t0v()) begin
        miscompares++; $display("FAIL alu_latency op%b got %h exp %h", ops[k], got, t0v());
      end
    end
  endtask

  task automatic test_store();
    exec(5'b00010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL st cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({obs_q[6][READ], obs_q[6][MDRIN], obs_q[7][READ], obs_q[7][RAMIN]} !== 4'b0101) begin
      miscompares++;
      $display("FAIL st_strobes got %b exp 0101",
               {obs_q[6][READ], obs_q[6][MDRIN], obs_q[7][READ], obs_q[7][RAMIN]});
    end
    got = sample(); vectors++;
    if (got !== t0v()) begin
      miscompares++; $display("FAIL st_latency got %h exp %h", got, t0v());
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 2; c++) begin
      exec(5'b10010, 1'(c), 1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL brx con%0d cyc%0d got %h exp %h", c, i, obs_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (obs_q[6][PCIN] !== 1'(c)) begin
        miscompares++; $display("FAIL brx_pcin con%0d got %b exp %b", c, obs_q[6][PCIN], 1'(c));
      end
      got = sample(); vectors++;
      if (got !== t0v()) begin
        miscompares++; $display("FAIL brx_latency con%0d got %h exp %h", c, got, t0v());
      end
    end
  endtask

  task automatic test_mul_div();
    logic [4:0] ops[2];
    ops = '{5'b01111, 5'b10000};
    foreach (ops[k]) begin
      exec(ops[k], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL muldiv op%b cyc%0d got %h exp %h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
      vectors++;
      if ({obs_q[3][RIN], obs_q[4][RIN], obs_q[5][RIN], obs_q[6][RIN],
           obs_q[5][LOIN], obs_q[6][HIIN]} !== 6'b000011) begin
        miscompares++;
        $display("FAIL muldiv_rin_lo_hi op%b got %b exp 000011", ops[k],
                 {obs_q[3][RIN], obs_q[4][RIN], obs_q[5][RIN], obs_q[6][RIN],
                  obs_q[5][LOIN], obs_q[6][HIIN]});
      end
    end
  endtask

  task automatic test_stop_halt();
    exec(5'b01100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL addi_stop cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      got = sample(); vectors++;
      if (got !== '0) begin
        miscompares++; $display("FAIL halt_hold%0d got %h exp %h", i, got, vec_t'(0));
      end
      tick();
    end
    recover();
    got = sample(); vectors++;
    if (got !== t0v()) begin
      miscompares++; $display("FAIL halt_recover got %h exp %h", got, t0v());
    end
  endtask

  task automatic test_clear_mid_ld();
    ctrl.opcode = 5'b00000; ctrl.CON_FF = 1'b0; ctrl.Stop = 1'b0;
    build_expect(5'b00000, 1'b0);
    repeat (5) tick();
    got = sample(); vectors++;
    if (got !== exp_q[5]) begin
      miscompares++; $display("FAIL ld_t5 got %h exp %h", got, exp_q[5]);
    end
    Clear = 1'b1; tick();
    got = sample(); vectors++;
    if (got !== '0) begin
      miscompares++; $display("FAIL clear_mid_ld got %h exp %h", got, vec_t'(0));
    end
    Clear = 1'b0; tick();
    got = sample(); vectors++;
    if (got !== t0v()) begin
      miscompares++; $display("FAIL clear_mid_ld_t0 got %h exp %h", got, t0v());
    end
  endtask

  task automatic test_clear_wins();
    ctrl.opcode = 5'b10011; ctrl.CON_FF = 1'b0;
    repeat (3) tick();
    ctrl.Stop = 1'b1; Clear = 1'b1; tick();
    got = sample(); vectors++;
    if (got !== '0) begin
      miscompares++; $display("FAIL clear_stop got %h exp %h", got, vec_t'(0));
    end
    ctrl.Stop = 1'b0; Clear = 1'b0; tick();
    got = sample(); vectors++;
    if (got !== t0v()) begin
      miscompares++; $display("FAIL clear_stop_t0 got %h exp %h", got, t0v());
    end
  endtask

  task automatic test_halt_opcode();
    exec(5'b11010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL halt_op cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      got = sample(); vectors++;
      if (got !== '0) begin
        miscompares++; $display("FAIL halt_op_hold%0d got %h exp %h", i, got, vec_t'(0));
      end
      tick();
    end
    recover();
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11010) op = 5'b11001;
      exec(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d op%b cyc%0d got %h exp %h", n, op, i, obs_q[i], exp_q[i]);
        end
        vectors++;
        if ($countones(obs_q[i][ROUT:PCOUT]) > 1) begin
          miscompares++;
          $display("FAIL bus_excl rand%0d cyc%0d got %b exp at most one", n, i,
                   obs_q[i][ROUT:PCOUT]);
        end
      end
    end
    got = sample(); vectors++;
    if (got !== t0v()) begin
      miscompares++; $display("FAIL rand_end_t0 got %h exp %h", got, t0v());
    end
  endtask

  initial begin
    Clear = 1'b1;
    ctrl.opcode = '0; ctrl.CON_FF = 1'b0; ctrl.Stop = 1'b0;
    #1;
    test_reset();
    test_alu_reg();
    test_store();
    test_branch();
    test_mul_div();
    test_stop_halt();
    test_clear_mid_ld();
    test_clear_wins();
    test_halt_opcode();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
